// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bundle of the fetch stage's ROM bus, decode handshake,
//                branch LUT write port and run-control signals.
//                master = fetch unit side, slave = ROM/decoder/top side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int LUT_AW  = 4
);
    logic               start;
    logic               done;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    instr_pc;
    logic               stall;
    logic               branch_taken;
    logic [LUT_AW-1:0]  branch_idx;
    logic               lut_we;
    logic [LUT_AW-1:0]  lut_waddr;
    logic [PC_W-1:0]    lut_wdata;
    logic [15:0]        instr_count;

    modport master (
        input  start, imem_data, stall, branch_taken, branch_idx,
               lut_we, lut_waddr, lut_wdata,
        output done, imem_addr, instr, instr_valid, instr_pc, instr_count
    );

    modport slave (
        output start, imem_data, stall, branch_taken, branch_idx,
               lut_we, lut_waddr, lut_wdata,
        input  done, imem_addr, instr, instr_valid, instr_pc, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, drives a synchronous
//                instruction ROM (1-cycle read latency) and hands one word
//                per cycle to decode. Taken branches redirect through a
//                loadable branch-target LUT with a single bubble; the halt
//                word ends the run and raises done.
//                Build option BRANCH_REL_EN: LUT entries are signed offsets
//                added to the branching instruction's PC instead of absolute
//                targets.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter int                 LUT_AW    = 4,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fetch_if.master   bus
);

    localparam int LUT_N = 1 << LUT_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
    // The word arriving from the ROM this cycle belongs to the program path.
    logic              live_q,     live_d;
    logic [15:0]       count_q,    count_d;
    logic [PC_W-1:0]   lut_q [LUT_N];
    logic [PC_W-1:0]   lut_d [LUT_N];

    logic              w_is_halt;
    logic              w_instr_valid;
    logic              w_hold;
    logic              w_retire;
    logic              w_branch;
    logic              w_halt_seen;
    logic [PC_W-1:0]   w_imem_addr;
    logic [PC_W-1:0]   w_lut_rd;
    logic [PC_W-1:0]   w_target;

    // Decode-side qualifiers derived from the current state and returning word
    always_comb begin
        w_is_halt     = (bus.imem_data == HALT_WORD);
        w_instr_valid = (state_q == S_RUN) && live_q && !w_is_halt;
        // A halt word is never valid, so a stall cannot hold it back
        w_halt_seen   = (state_q == S_RUN) && live_q && w_is_halt;
        w_hold        = bus.stall && w_instr_valid;
        w_retire      = w_instr_valid && !bus.stall;
        w_branch      = w_retire && bus.branch_taken;
        // Re-reading instr_pc while held makes the ROM return the same word
        w_imem_addr   = w_hold ? instr_pc_q : fetch_pc_q;
        // Reads see the pre-write LUT contents on a same-index collision
        w_lut_rd      = lut_q[bus.branch_idx];
`ifdef BRANCH_REL_EN
        // Same width as the PC, so modular addition equals sign-extended add
        w_target      = instr_pc_q + w_lut_rd;
`else
        w_target      = w_lut_rd;
`endif
    end

    // Next-state computation for the fetch FSM, PC, counter and LUT
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_pc_d = instr_pc_q;
        live_d     = live_q;
        count_d    = count_q;
        lut_d      = lut_q;

        if (bus.lut_we) begin
            lut_d[bus.lut_waddr] = bus.lut_wdata;
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    fetch_pc_d = '0;
                    count_d    = '0;
                    live_d     = 1'b0;
                end
            end
            S_RUN: begin
                instr_pc_d = w_imem_addr;
                if (w_hold) begin
                    live_d = 1'b1;
                end else if (w_halt_seen) begin
                    state_d = S_HALT;
                    live_d  = 1'b0;
                end else if (w_branch) begin
                    // The address issued this cycle is wrong-path
                    fetch_pc_d = w_target;
                    state_d    = S_FLUSH;
                    live_d     = 1'b0;
                end else begin
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                    live_d     = 1'b1;
                end
                if (w_retire && (count_q != 16'hFFFF)) begin
                    count_d = count_q + 16'd1;
                end
            end
            S_FLUSH: begin
                // Bubble cycle: the branch target is issued here
                instr_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(1);
                live_d     = 1'b1;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear of everything including the LUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            instr_pc_q <= '0;
            live_q     <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_pc_q <= instr_pc_d;
            live_q     <= live_d;
            count_q    <= count_d;
            lut_q      <= lut_d;
        end
    end

    assign bus.imem_addr   = w_imem_addr;
    assign bus.instr       = w_instr_valid ? bus.imem_data : '0;
    assign bus.instr_valid = w_instr_valid;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.done        = (state_q == S_HALT);
    assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: a cycle table for a
//                short program, directed branch/stall/wrap/reset sequences,
//                and a randomized run checked against a program-walk model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int         PC_W    = 10;
    localparam int         INSTR_W = 9;
    localparam int         LUT_AW  = 4;
    localparam logic [8:0] HALT    = 9'h1FF;
`ifdef BRANCH_REL_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_AW(LUT_AW)) bus ();

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_AW(LUT_AW), .HALT_WORD(HALT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Synchronous instruction ROM
    logic [8:0] rom [1024];
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    logic [9:0] mlut [16];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] tgt(input logic [9:0] pc, input logic [9:0] e);
        return REL ? 10'(pc + e) : e;
    endfunction

    task automatic clear_inputs();
        bus.start        = 1'b0;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_idx   = '0;
        bus.lut_we       = 1'b0;
        bus.lut_waddr    = '0;
        bus.lut_wdata    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mlut[i] = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [9:0] val);
        @(negedge clk);
        bus.lut_we = 1'b1; bus.lut_waddr = idx; bus.lut_wdata = val;
        @(negedge clk);
        bus.lut_we = 1'b0;
        mlut[idx] = val;
    endtask

    // Returns at negedge+1 of the cycle presenting a valid word at pc
    task automatic wait_pc(input logic [9:0] pc);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk); #1;
            if (bus.instr_valid && bus.instr_pc == pc) return;
        end
        check("wait_pc_timeout", 32'(bus.instr_pc), 32'(pc));
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'(i)};
    endtask

    typedef struct {
        bit        start;
        bit        e_valid;
        bit [8:0]  e_instr;
        bit [9:0]  e_pc;
        bit [9:0]  e_addr;
        bit        e_done;
        bit [15:0] e_cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [9:0] exp_pc;
        logic [9:0] mpc;
        bit         exp_halt;
        int         mcnt;
        int         idle;
        logic [8:0] w;
        logic [3:0] idx;
        logic [3:0] wa;
        logic [9:0] wd;

        //                start valid instr   pc     addr   done cnt
        tbl[0] = '{1'b1, 1'b0, 9'h000, 10'd0, 10'd0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 9'h000, 10'd0, 10'd0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 9'h001, 10'd0, 10'd1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 9'h002, 10'd1, 10'd2, 1'b0, 16'd1};
        tbl[4] = '{1'b0, 1'b1, 9'h003, 10'd2, 10'd3, 1'b0, 16'd2};
        tbl[5] = '{1'b0, 1'b0, 9'h000, 10'd0, 10'd4, 1'b0, 16'd3};
        tbl[6] = '{1'b0, 1'b0, 9'h000, 10'd0, 10'd4, 1'b1, 16'd3};
        tbl[7] = '{1'b0, 1'b0, 9'h000, 10'd0, 10'd4, 1'b1, 16'd3};

        // ---- reset state ----
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = HALT;
        do_reset();
        @(negedge clk); #1;
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_done",  32'(bus.done),        32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);
        check("rst_pc",    32'(bus.instr_pc),    32'd0);
        check("rst_instr", 32'(bus.instr),       32'd0);

        // ---- table: short program ending in halt ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start = tbl[i].start;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_addr", i),  32'(bus.imem_addr),   32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_done", i),  32'(bus.done),        32'(tbl[i].e_done));
            check($sformatf("tbl%0d_cnt", i),   32'(bus.instr_count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_instr", i), 32'(bus.instr),    32'(tbl[i].e_instr));
                check($sformatf("tbl%0d_pc", i),    32'(bus.instr_pc), 32'(tbl[i].e_pc));
            end
        end
        bus.start = 1'b0;

        // ---- branch with one bubble; branch_taken ignored during bubble ----
        fill_linear();
        do_reset();
        lut_write(4'd2, 10'd8);
        pulse_start();
        wait_pc(10'd1);
        bus.branch_taken = 1'b1; bus.branch_idx = 4'd2;
        @(negedge clk); #1;
        check("br_bubble_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk); bus.branch_taken = 1'b0; #1;
        exp_pc = tgt(10'd1, 10'd8);
        check("br_tgt_valid", 32'(bus.instr_valid), 32'd1);
        check("br_tgt_pc",    32'(bus.instr_pc),    32'(exp_pc));
        check("br_tgt_instr", 32'(bus.instr),       32'(rom[exp_pc]));
        check("br_tgt_cnt",   32'(bus.instr_count), 32'd2);
        @(negedge clk); #1;
        check("br_next_pc",   32'(bus.instr_pc),    32'(10'(exp_pc + 10'd1)));

`ifdef BRANCH_REL_EN
        // ---- relative branch with negative offset ----
        do_reset();
        lut_write(4'd1, 10'h3FE);
        pulse_start();
        wait_pc(10'd20);
        bus.branch_taken = 1'b1; bus.branch_idx = 4'd1;
        @(negedge clk); bus.branch_taken = 1'b0;
        @(negedge clk); #1;
        check("rel_tgt_pc", 32'(bus.instr_pc), 32'd18);
`endif

        // ---- stall holds instr, pc, count; no word skipped on release ----
        do_reset();
        pulse_start();
        wait_pc(10'd5);
        bus.stall = 1'b1; #1;
        check("stall0_addr", 32'(bus.imem_addr), 32'd5);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("stall%0d_valid", k), 32'(bus.instr_valid), 32'd1);
            check($sformatf("stall%0d_pc", k),    32'(bus.instr_pc),    32'd5);
            check($sformatf("stall%0d_instr", k), 32'(bus.instr),       32'(rom[5]));
            check($sformatf("stall%0d_cnt", k),   32'(bus.instr_count), 32'd5);
            check($sformatf("stall%0d_addr", k),  32'(bus.imem_addr),   32'd5);
        end
        @(negedge clk); bus.stall = 1'b0; #1;
        check("stall_rel_pc",  32'(bus.instr_pc),    32'd5);
        check("stall_rel_cnt", 32'(bus.instr_count), 32'd5);
        @(negedge clk); #1;
        check("stall_after_pc",  32'(bus.instr_pc),    32'd6);
        check("stall_after_cnt", 32'(bus.instr_count), 32'd6);

        // ---- PC wrap 1023 -> 0 ----
        do_reset();
        lut_write(4'd3, 10'd100);
        pulse_start();
        wait_pc(10'd1023);
        check("wrap_cnt_a", 32'(bus.instr_count), 32'd1023);
        @(negedge clk); #1;
        check("wrap_valid", 32'(bus.instr_valid), 32'd1);
        check("wrap_pc",    32'(bus.instr_pc),    32'd0);
        check("wrap_cnt_b", 32'(bus.instr_count), 32'd1024);

        // ---- asynchronous reset mid-run clears outputs and LUT ----
        #1; rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.instr_valid), 32'd0);
        check("arst_done",  32'(bus.done),        32'd0);
        check("arst_cnt",   32'(bus.instr_count), 32'd0);
        @(negedge clk); #2; rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mlut[i] = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("arst_idle%0d", k), 32'(bus.instr_valid), 32'd0);
        end
        pulse_start();
        wait_pc(10'd2);
        bus.branch_taken = 1'b1; bus.branch_idx = 4'd3;
        @(negedge clk); bus.branch_taken = 1'b0;
        @(negedge clk); #1;
        check("arst_lut_pc", 32'(bus.instr_pc), 32'(tgt(10'd2, 10'd0)));

        // ---- randomized run against a program-walk model ----
        for (int i = 0; i < 1024; i++) begin
            w = 9'($urandom_range(0, 510));
            if ($urandom_range(0, 59) == 0) w = HALT;
            rom[i] = w;
        end
        do_reset();
        @(negedge clk);
        bus.start = 1'b1;
        mpc = '0; mcnt = 0; idle = 0;
        exp_halt = (rom[0] == HALT);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            check("rnd_cnt", 32'(bus.instr_count), 32'(mcnt));
            if (bus.done) begin
                check("rnd_halt_expected", 32'(exp_halt), 32'd1);
                bus.start = 1'b1;
                mpc = '0; mcnt = 0; idle = 0;
                exp_halt = (rom[0] == HALT);
            end else if (bus.instr_valid) begin
                idle = 0;
                check("rnd_pc",    32'(bus.instr_pc), 32'(mpc));
                check("rnd_instr", 32'(bus.instr),    32'(rom[mpc]));
                bus.stall = ($urandom_range(0, 3) == 0);
                if (!bus.stall) begin
                    mcnt++;
                    if ($urandom_range(0, 4) == 0) begin
                        idx = 4'($urandom_range(0, 15));
                        bus.branch_taken = 1'b1;
                        bus.branch_idx   = idx;
                        mpc = tgt(mpc, mlut[idx]);
                    end else begin
                        mpc = 10'(mpc + 10'd1);
                    end
                    exp_halt = (rom[mpc] == HALT);
                end
            end else begin
                idle++;
                if (!exp_halt) begin
                    bus.stall        = 1'($urandom_range(0, 1));
                    bus.branch_taken = 1'($urandom_range(0, 1));
                    bus.branch_idx   = 4'($urandom_range(0, 15));
                end
                if (idle > 6) begin
                    check("rnd_progress_timeout", 32'(idle), 32'd0);
                    break;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                wa = 4'($urandom_range(0, 15));
                wd = 10'($urandom_range(0, 1023));
                bus.lut_we    = 1'b1;
                bus.lut_waddr = wa;
                bus.lut_wdata = wd;
                mlut[wa] = wd;
            end
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
